pixel_byte_packer: RTL and testbench

- Upstream neighbour of the pixel buffer: accepts an 8-bit byte stream (R, G, B order) from the ingest interface and packs each triple into one 24-bit RGB word.
- Drives the buffer's write strobe and honours the buffer's full flag.
- Tracks column and line position within a frame and flags framing errors from a start-of-frame marker.

---
 rtl/pixel_byte_packer.sv | 137 +++++++++++++
 tb/tb_pixel_byte_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_byte_packer.sv
// Packs an R,G,B byte stream into 24-bit pixels for the pixel buffer and tracks
// column/line position within a frame, flagging start-of-frame framing errors.
module pixel_byte_packer #(
  parameter int unsigned LINE_WIDTH  = 1280,
  parameter int unsigned FRAME_LINES = 720,
  parameter int unsigned COL_W       = 11,
  parameter int unsigned LINE_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  input  logic              sofIn,
  output logic              byteReady,
  input  logic              bufferFull,
  output logic              writeEn,
  output logic [23:0]       pixelRGB,
  output logic [COL_W-1:0]  pixelAddress,
  output logic [LINE_W-1:0] lineCount,
  output logic              eolPulse,
  output logic              eofPulse,
  output logic              frameError,
  input  logic              errClear
);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    GOT_R    = 2'd1,
    GOT_G    = 2'd2,
    EXPECT_R = 2'd3
  } state_t;

  state_t             state, stateNext;
  logic               pending, pendingNext;
  logic [7:0]         rReg, gReg, rNext, gNext;
  logic [23:0]        pixelNext;
  logic [COL_W-1:0]   addrNext, advAddr;
  logic [LINE_W-1:0]  lineNext, advLine;
  logic               errNext;
  logic               accept, lastCol, lastLine, sofLegal;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WAIT_SOF;
      pending      <= 1'b0;
      rReg         <= 8'd0;
      gReg         <= 8'd0;
      pixelRGB     <= 24'd0;
      pixelAddress <= '0;
      lineCount    <= '0;
      frameError   <= 1'b0;
    end else begin
      state        <= stateNext;
      pending      <= pendingNext;
      rReg         <= rNext;
      gReg         <= gNext;
      pixelRGB     <= pixelNext;
      pixelAddress <= addrNext;
      lineCount    <= lineNext;
      frameError   <= errNext;
    end
  end

  // Handshake, write strobe, position advance and next-state logic
  always_comb begin
    byteReady = !(pending && bufferFull);
    writeEn   = pending && !bufferFull;
    accept    = byteValid && byteReady;
    lastCol   = (pixelAddress == LAST_COL);
    lastLine  = (lineCount == LAST_LINE);
    eolPulse  = writeEn && lastCol;
    eofPulse  = eolPulse && lastLine;

    // Position after this cycle's write; also the position of a pixel completed now
    advAddr = pixelAddress;
    advLine = lineCount;
    if (writeEn) begin
      if (lastCol) begin
        advAddr = '0;
        advLine = lastLine ? '0 : lineCount + LINE_W'(1);
      end else begin
        advAddr = pixelAddress + COL_W'(1);
      end
    end

    sofLegal    = (state == WAIT_SOF) ||
                  ((state == EXPECT_R) && (advAddr == '0) && (advLine == '0));
    stateNext   = state;
    pendingNext = pending && !writeEn;
    rNext       = rReg;
    gNext       = gReg;
    pixelNext   = pixelRGB;
    addrNext    = advAddr;
    lineNext    = advLine;
    errNext     = frameError && !errClear;

    if (accept) begin
      if (sofIn && !sofLegal) begin
        // Resynchronise on the unexpected SOF: this byte starts a new pixel at (0,0)
        errNext   = 1'b1;
        rNext     = byteIn;
        stateNext = GOT_R;
        addrNext  = '0;
        lineNext  = '0;
      end else begin
        unique case (state)
          WAIT_SOF: begin
            if (sofIn) begin
              rNext     = byteIn;
              stateNext = GOT_R;
            end
          end
          GOT_R: begin
            gNext     = byteIn;
            stateNext = GOT_G;
          end
          GOT_G: begin
            pixelNext   = {rReg, gReg, byteIn};
            pendingNext = 1'b1;
            stateNext   = ((advAddr == LAST_COL) && (advLine == LAST_LINE)) ? WAIT_SOF
                                                                           : EXPECT_R;
          end
          EXPECT_R: begin
            rNext     = byteIn;
            stateNext = GOT_R;
          end
          default: stateNext = WAIT_SOF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_byte_packer.sv
// Directed bench for pixel_byte_packer using a 4x2 frame.
module tb_pixel_byte_packer;

  localparam int unsigned LW = 4;
  localparam int unsigned FL = 2;
  localparam int unsigned CW = 3;
  localparam int unsigned LNW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     byteIn = 8'd0;
  logic           byteValid = 1'b0;
  logic           sofIn = 1'b0;
  logic           byteReady;
  logic           bufferFull = 1'b0;
  logic           writeEn;
  logic [23:0]    pixelRGB;
  logic [CW-1:0]  pixelAddress;
  logic [LNW-1:0] lineCount;
  logic           eolPulse;
  logic           eofPulse;
  logic           frameError;
  logic           errClear = 1'b0;

  int tests = 0;
  int fails = 0;

  pixel_byte_packer #(
    .LINE_WIDTH(LW), .FRAME_LINES(FL), .COL_W(CW), .LINE_W(LNW)
  ) dut (
    .clk(clk), .rst(rst), .byteIn(byteIn), .byteValid(byteValid), .sofIn(sofIn),
    .byteReady(byteReady), .bufferFull(bufferFull), .writeEn(writeEn),
    .pixelRGB(pixelRGB), .pixelAddress(pixelAddress), .lineCount(lineCount),
    .eolPulse(eolPulse), .eofPulse(eofPulse), .frameError(frameError),
    .errClear(errClear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] b, input logic s);
    byteValid = v;
    byteIn    = b;
    sofIn     = s;
  endtask

  task automatic doReset();
    drv(1'b0, 8'd0, 1'b0);
    bufferFull = 1'b0;
    errClear   = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int w;
    // Reset state
    #1;
    chk("rst_writeEn", 32'(writeEn), 32'd0);
    chk("rst_byteReady", 32'(byteReady), 32'd1);
    chk("rst_pixel", 32'(pixelRGB), 32'd0);
    chk("rst_addr", 32'(pixelAddress), 32'd0);
    chk("rst_line", 32'(lineCount), 32'd0);
    chk("rst_err", 32'(frameError), 32'd0);
    tick();
    rst = 1'b0;

    // Basic triple
    drv(1, 8'h11, 1); chk("t1_ready0", 32'(byteReady), 32'd1); tick();
    drv(1, 8'h22, 0); chk("t1_ready1", 32'(byteReady), 32'd1); tick();
    drv(1, 8'h33, 0); chk("t1_noWrite", 32'(writeEn), 32'd0); tick();
    drv(0, 8'h00, 0);
    chk("t1_writeEn", 32'(writeEn), 32'd1);
    chk("t1_pixel", 32'(pixelRGB), 32'h112233);
    chk("t1_addr", 32'(pixelAddress), 32'd0);
    chk("t1_line", 32'(lineCount), 32'd0);
    chk("t1_ready2", 32'(byteReady), 32'd1);
    tick();
    chk("t1_oneWrite", 32'(writeEn), 32'd0);
    chk("t1_addrInc", 32'(pixelAddress), 32'd1);

    // Bytes without SOF are dropped
    doReset();
    drv(1, 8'hAA, 0); tick();
    drv(1, 8'hBB, 0); tick();
    drv(1, 8'hCC, 0); tick();
    drv(0, 8'h00, 0);
    chk("t2_noWrite", 32'(writeEn), 32'd0);
    chk("t2_noErr", 32'(frameError), 32'd0);
    drv(1, 8'h01, 1); tick();
    drv(1, 8'h02, 0); tick();
    drv(1, 8'h03, 0); tick();
    drv(0, 8'h00, 0);
    chk("t2_writeEn", 32'(writeEn), 32'd1);
    chk("t2_pixel", 32'(pixelRGB), 32'h010203);
    chk("t2_addr", 32'(pixelAddress), 32'd0);
    tick();

    // Backpressure from bufferFull
    drv(1, 8'h44, 0); tick();
    drv(1, 8'h55, 0); tick();
    drv(1, 8'h66, 0); bufferFull = 1'b1;
    chk("t3_readyB", 32'(byteReady), 32'd1);
    tick();
    drv(1, 8'h77, 0);
    chk("t3_readyLow", 32'(byteReady), 32'd0);
    chk("t3_noWrite", 32'(writeEn), 32'd0);
    chk("t3_pixel", 32'(pixelRGB), 32'h445566);
    tick();
    chk("t3_readyLow2", 32'(byteReady), 32'd0);
    chk("t3_stable", 32'(pixelRGB), 32'h445566);
    chk("t3_addrHold", 32'(pixelAddress), 32'd1);
    bufferFull = 1'b0;
    #1;
    chk("t3_writeEn", 32'(writeEn), 32'd1);
    chk("t3_readyHigh", 32'(byteReady), 32'd1);
    tick();
    chk("t3_oneWrite", 32'(writeEn), 32'd0);
    chk("t3_addrInc", 32'(pixelAddress), 32'd2);
    drv(1, 8'h88, 0); tick();
    drv(1, 8'h99, 0); tick();
    drv(0, 8'h00, 0);
    chk("t3_writeEn2", 32'(writeEn), 32'd1);
    chk("t3_pixel2", 32'(pixelRGB), 32'h778899);
    chk("t3_addr2", 32'(pixelAddress), 32'd2);
    tick();

    // Full 4x2 frame, one byte per cycle
    doReset();
    for (int i = 0; i <= 24; i++) begin
      drv(i < 24, 8'(i + 1), i == 0);
      #1;
      if (i >= 3 && (i % 3) == 0) begin
        w = i / 3;
        chk("t4_writeEn", 32'(writeEn), 32'd1);
        chk("t4_addr", 32'(pixelAddress), 32'((w - 1) % 4));
        chk("t4_line", 32'(lineCount), 32'((w - 1) / 4));
        chk("t4_pixel", 32'(pixelRGB),
            {8'd0, 8'(3 * (w - 1) + 1), 8'(3 * (w - 1) + 2), 8'(3 * (w - 1) + 3)});
        chk("t4_eol", 32'(eolPulse), 32'(((w - 1) % 4) == 3));
        chk("t4_eof", 32'(eofPulse), 32'(w == 8));
      end else begin
        chk("t4_idleWrite", 32'(writeEn), 32'd0);
        chk("t4_idleEol", 32'(eolPulse), 32'd0);
      end
      tick();
    end
    chk("t4_addrWrap", 32'(pixelAddress), 32'd0);
    chk("t4_lineWrap", 32'(lineCount), 32'd0);
    drv(1, 8'hE1, 0); tick();
    drv(1, 8'hE2, 0); tick();
    drv(1, 8'hE3, 0); tick();
    drv(0, 8'h00, 0);
    chk("t4_waitSof", 32'(writeEn), 32'd0);
    tick();
    chk("t4_waitSof2", 32'(writeEn), 32'd0);

    // Mid-frame SOF
    doReset();
    for (int i = 0; i < 18; i++) begin
      drv(1, 8'(i + 1), i == 0);
      tick();
    end
    drv(0, 8'h00, 0); tick();
    chk("t5_addrPre", 32'(pixelAddress), 32'd2);
    chk("t5_linePre", 32'(lineCount), 32'd1);
    drv(1, 8'hA0, 0); tick();
    drv(1, 8'hA1, 1); tick();
    drv(0, 8'h00, 0);
    chk("t5_err", 32'(frameError), 32'd1);
    chk("t5_addr0", 32'(pixelAddress), 32'd0);
    chk("t5_line0", 32'(lineCount), 32'd0);
    drv(1, 8'hA2, 0); tick();
    drv(1, 8'hA3, 0); tick();
    drv(0, 8'h00, 0);
    chk("t5_writeEn", 32'(writeEn), 32'd1);
    chk("t5_pixel", 32'(pixelRGB), 32'hA1A2A3);
    chk("t5_addrW", 32'(pixelAddress), 32'd0);
    chk("t5_lineW", 32'(lineCount), 32'd0);
    tick();
    errClear = 1'b1; tick();
    errClear = 1'b0;
    chk("t5_cleared", 32'(frameError), 32'd0);
    drv(1, 8'hC0, 1); errClear = 1'b1; tick();
    drv(0, 8'h00, 0); errClear = 1'b0;
    chk("t5_setWins", 32'(frameError), 32'd1);

    // Reset with a pending pixel held by bufferFull
    drv(1, 8'hB1, 0); tick();
    drv(1, 8'hB2, 0); bufferFull = 1'b1; tick();
    drv(0, 8'h00, 0);
    chk("t6_readyLow", 32'(byteReady), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_writeEn", 32'(writeEn), 32'd0);
    chk("t6_ready", 32'(byteReady), 32'd1);
    chk("t6_addr", 32'(pixelAddress), 32'd0);
    chk("t6_line", 32'(lineCount), 32'd0);
    chk("t6_err", 32'(frameError), 32'd0);
    chk("t6_pixel", 32'(pixelRGB), 32'd0);
    tick();
    rst = 1'b0;
    bufferFull = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_noStale", 32'(writeEn), 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
